// File: rtl/boa_mtime_multi_pkg.sv
// Shared constants and helpers for the boa machine timer.
// Register word offsets, ctrl field positions, register-select decode and byte-merge helper.
package boa_mtime_multi_pkg;

  // Byte offsets from the register window base
  localparam logic [7:0] OFF_MTIME_LO  = 8'h00;
  localparam logic [7:0] OFF_MTIME_HI  = 8'h04;
  localparam logic [7:0] OFF_CTRL      = 8'h08;
  localparam logic [7:0] OFF_CMP_BASE  = 8'h10;  // + 8*h lo, + 8*h + 4 hi
  localparam logic [7:0] OFF_MSIP_BASE = 8'h80;  // + 4*h

  // ctrl field positions
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_DIV_LSB = 8;

  // Which register the current bus address selects
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_CTRL,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_MSIP
  } reg_sel_t;

  // Replace the bytes of old_word whose enable bit is set
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/boa_mem_bus.sv
// Simple single-cycle memory bus: byte-enabled writes, registered reads.
interface boa_mem_bus;
  logic [31:0] addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport MEM (input addr, input we, input wdata, output rdata, output ready);
  modport CPU (output addr, output we, output wdata, input rdata, input ready);
endinterface

// File: rtl/boa_mtime_cmp.sv
// One timer comparator channel: mtimecmp register with byte-enable writes
// and the registered level-sensitive interrupt (mtime >= mtimecmp).
module boa_mtime_cmp
  import boa_mtime_multi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [3:0]  i_we,
  input  logic [31:0] i_wdata,
  input  logic [63:0] i_mtime,
  output logic [63:0] o_cmp,
  output logic        o_irq
);

  logic [63:0] r_cmp;
  logic        r_irq;

  // Compare register update and one-cycle-lagged interrupt evaluation
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cmp <= '1;
      r_irq <= 1'b0;
    end else begin
      if (i_wr_lo) r_cmp[31:0]  <= byte_merge(r_cmp[31:0],  i_wdata, i_we);
      if (i_wr_hi) r_cmp[63:32] <= byte_merge(r_cmp[63:32], i_wdata, i_we);
      r_irq <= (i_mtime >= r_cmp);
    end
  end

  assign o_cmp = r_cmp;
  assign o_irq = r_irq;

endmodule

// File: rtl/boa_mtime_multi.sv
// Multi-hart machine timer: 64-bit mtime with prescaler, per-hart mtimecmp
// comparators and interrupts, zero-wait bus with registered read data.
// Optional per-hart software interrupt (msip/swi) when BOA_MTIME_SWI_EN is defined.
module boa_mtime_multi
  import boa_mtime_multi_pkg::*;
#(
  parameter logic [31:0] addr           = 32'hffff_f000,
  parameter int          harts          = 1,
  parameter int          prescale_width = 8
) (
  input  logic             clk,
  input  logic             rst,
  boa_mem_bus.MEM          bus,
  output logic [harts-1:0] irq
`ifdef BOA_MTIME_SWI_EN
  ,
  output logic [harts-1:0] swi
`endif
);

  localparam logic [5:0] W_MT_LO = OFF_MTIME_LO[7:2];
  localparam logic [5:0] W_MT_HI = OFF_MTIME_HI[7:2];
  localparam logic [5:0] W_CTRL  = OFF_CTRL[7:2];
  localparam int         CMP_W0  = int'(OFF_CMP_BASE[7:2]);
`ifdef BOA_MTIME_SWI_EN
  localparam int         MSIP_W0 = int'(OFF_MSIP_BASE[7:2]);
`endif

  logic [63:0]               r_mtime;
  logic [prescale_width-1:0] r_pre;
  logic                      r_en;
  logic [prescale_width-1:0] r_div;
  logic [31:0]               r_rdata;
`ifdef BOA_MTIME_SWI_EN
  logic [harts-1:0]          r_msip;
`endif

  logic [31:0] w_off;
  logic        w_in_win;
  logic [5:0]  w_word;
  logic        w_wr;
  reg_sel_t    w_sel;
  logic [2:0]  w_hart;
  logic [31:0] w_ctrl;
  logic [31:0] w_rd;
  logic        w_wr_mt_lo;
  logic        w_wr_mt_hi;
  logic [63:0] w_cmp [harts];
  logic [harts-1:0] w_irq;

  // Misaligned addresses fall outside every register and read as zero
  assign w_off    = bus.addr - addr;
  assign w_in_win = (w_off[31:8] == 24'd0) && (w_off[1:0] == 2'b00);
  assign w_word   = w_off[7:2];
  assign w_wr     = (bus.we != 4'b0000);

  assign w_ctrl = (32'(r_div) << CTRL_DIV_LSB) | (32'(r_en) << CTRL_EN_BIT);

  // Address decode to a register select and hart index; harts beyond the parameter stay unmapped
  always_comb begin
    w_sel  = SEL_NONE;
    w_hart = '0;
    if (w_in_win) begin
      if (w_word == W_MT_LO)      w_sel = SEL_MTIME_LO;
      else if (w_word == W_MT_HI) w_sel = SEL_MTIME_HI;
      else if (w_word == W_CTRL)  w_sel = SEL_CTRL;
      else begin
        for (int h = 0; h < harts; h++) begin
          if (w_word == 6'(CMP_W0 + 2*h)) begin
            w_sel  = SEL_CMP_LO;
            w_hart = 3'(h);
          end
          if (w_word == 6'(CMP_W0 + 2*h + 1)) begin
            w_sel  = SEL_CMP_HI;
            w_hart = 3'(h);
          end
`ifdef BOA_MTIME_SWI_EN
          if (w_word == 6'(MSIP_W0 + h)) begin
            w_sel  = SEL_MSIP;
            w_hart = 3'(h);
          end
`endif
        end
      end
    end
  end

  assign w_wr_mt_lo = w_wr && (w_sel == SEL_MTIME_LO);
  assign w_wr_mt_hi = w_wr && (w_sel == SEL_MTIME_HI);

  // Read data mux for the selected register
  always_comb begin
    w_rd = '0;
    case (w_sel)
      SEL_MTIME_LO: w_rd = r_mtime[31:0];
      SEL_MTIME_HI: w_rd = r_mtime[63:32];
      SEL_CTRL:     w_rd = w_ctrl;
      SEL_CMP_LO, SEL_CMP_HI: begin
        for (int h = 0; h < harts; h++) begin
          if (w_hart == 3'(h)) w_rd = (w_sel == SEL_CMP_HI) ? w_cmp[h][63:32] : w_cmp[h][31:0];
        end
      end
`ifdef BOA_MTIME_SWI_EN
      SEL_MSIP: begin
        for (int h = 0; h < harts; h++) begin
          if (w_hart == 3'(h)) w_rd = {31'd0, r_msip[h]};
        end
      end
`endif
      default: w_rd = '0;
    endcase
  end

  // mtime and prescaler: bus writes win over counting and restart the prescaler.
  // The >= compare also recovers cleanly when div is lowered below the running count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mtime <= '0;
      r_pre   <= '0;
    end else if (w_wr_mt_lo || w_wr_mt_hi) begin
      if (w_wr_mt_lo) r_mtime[31:0]  <= byte_merge(r_mtime[31:0],  bus.wdata, bus.we);
      if (w_wr_mt_hi) r_mtime[63:32] <= byte_merge(r_mtime[63:32], bus.wdata, bus.we);
      r_pre <= '0;
    end else if (r_en) begin
      if (r_pre >= r_div) begin
        r_pre   <= '0;
        r_mtime <= r_mtime + 64'd1;
      end else begin
        r_pre <= r_pre + prescale_width'(1);
      end
    end
  end

  // ctrl register: enable and divider, each bit written under its own byte enable
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_en  <= 1'b1;
      r_div <= '0;
    end else if (w_wr && (w_sel == SEL_CTRL)) begin
      if (bus.we[CTRL_EN_BIT/8]) r_en <= bus.wdata[CTRL_EN_BIT];
      for (int i = 0; i < prescale_width; i++) begin
        if (bus.we[(CTRL_DIV_LSB + i) / 8]) r_div[i] <= bus.wdata[CTRL_DIV_LSB + i];
      end
    end
  end

  // Registered read data
  always_ff @(posedge clk) begin
    if (!rst) r_rdata <= '0;
    else      r_rdata <= w_rd;
  end

  assign bus.rdata = r_rdata;
  assign bus.ready = 1'b1;

  for (genvar gi = 0; gi < harts; gi++) begin : g_cmp
    boa_mtime_cmp u_cmp (
      .clk     (clk),
      .rst     (rst),
      .i_wr_lo (w_wr && (w_sel == SEL_CMP_LO) && (w_hart == 3'(gi))),
      .i_wr_hi (w_wr && (w_sel == SEL_CMP_HI) && (w_hart == 3'(gi))),
      .i_we    (bus.we),
      .i_wdata (bus.wdata),
      .i_mtime (r_mtime),
      .o_cmp   (w_cmp[gi]),
      .o_irq   (w_irq[gi])
    );
  end

  assign irq = w_irq;

`ifdef BOA_MTIME_SWI_EN
  // Software interrupt pending bits, only bit 0 of each word is storage
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_msip <= '0;
    end else begin
      for (int h = 0; h < harts; h++) begin
        if (w_wr && (w_sel == SEL_MSIP) && (w_hart == 3'(h)) && bus.we[0]) r_msip[h] <= bus.wdata[0];
      end
    end
  end

  assign swi = r_msip;
`endif

endmodule

// File: tb/tb_boa_mtime_multi.sv
// Self-checking bench for boa_mtime_multi (4 harts); define BOA_MTIME_SWI_EN to exercise msip/swi.
module tb_boa_mtime_multi;

  localparam int          HARTS = 4;
  localparam logic [31:0] BASE  = 32'hffff_f000;
`ifdef BOA_MTIME_SWI_EN
  localparam logic [31:0] MSIP_RD = 32'h1;
`else
  localparam logic [31:0] MSIP_RD = 32'h0;
`endif

  logic             clk;
  logic             rst;
  logic [HARTS-1:0] irq;
`ifdef BOA_MTIME_SWI_EN
  logic [HARTS-1:0] swi;
`endif

  boa_mem_bus bus();

  boa_mtime_multi #(.addr(BASE), .harts(HARTS), .prescale_width(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .irq (irq)
`ifdef BOA_MTIME_SWI_EN
    ,
    .swi (swi)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  we;
    logic [31:0] wd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge
  task automatic bwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = we;
    @(negedge clk);
    bus.we    = 4'b0000;
  endtask

  task automatic bread(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.we   = 4'b0000;
    @(negedge clk);
    d = bus.rdata;
  endtask

  logic [31:0] rd;

  initial begin
    vecs.push_back('{BASE + 32'h08, 4'h0, 32'h0,         32'h0000_0001, "ctrl_reset"});
    vecs.push_back('{BASE + 32'h10, 4'h0, 32'h0,         32'hffff_ffff, "cmp0_lo_reset"});
    vecs.push_back('{BASE + 32'h14, 4'h0, 32'h0,         32'hffff_ffff, "cmp0_hi_reset"});
    vecs.push_back('{BASE + 32'h18, 4'hf, 32'h1234_5678, 32'h1234_5678, "cmp1_lo_full"});
    vecs.push_back('{BASE + 32'h18, 4'h1, 32'h0000_00ab, 32'h1234_56ab, "cmp1_lo_b0"});
    vecs.push_back('{BASE + 32'h18, 4'h4, 32'h00cd_0000, 32'h12cd_56ab, "cmp1_lo_b2"});
    vecs.push_back('{BASE + 32'h2c, 4'hf, 32'haaaa_5555, 32'haaaa_5555, "cmp3_hi"});
    vecs.push_back('{BASE + 32'h30, 4'hf, 32'h0000_0001, 32'h0,         "cmp4_unmapped"});
    vecs.push_back('{BASE + 32'h0c, 4'hf, 32'hffff_ffff, 32'h0,         "off0c_unmapped"});
    vecs.push_back('{BASE + 32'hc0, 4'hf, 32'hffff_ffff, 32'h0,         "offc0_unmapped"});
    vecs.push_back('{BASE + 32'h80, 4'hf, 32'hffff_ffff, MSIP_RD,       "msip0_set"});
    vecs.push_back('{BASE + 32'h80, 4'hf, 32'h0,         32'h0,         "msip0_clr"});
    vecs.push_back('{BASE + 32'h90, 4'hf, 32'h1,         32'h0,         "msip4_unmapped"});
    vecs.push_back('{BASE + 32'h08, 4'hf, 32'hffff_ff01, 32'h0000_ff01, "ctrl_div_ff"});
    vecs.push_back('{BASE + 32'h08, 4'hf, 32'h0000_0001, 32'h0000_0001, "ctrl_restore"});
    vecs.push_back('{32'hffff_e010, 4'h0, 32'h0,         32'h0,         "below_window"});

    // Reset, with a competing write to mtime that must lose
    rst       = 1'b0;
    bus.addr  = BASE;
    bus.wdata = 32'h0000_0055;
    bus.we    = 4'hf;
    repeat (3) @(negedge clk);
    bus.we   = 4'h0;
    bus.addr = BASE + 32'h08;
    @(negedge clk);
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_ready", 32'(bus.ready), 32'h1);

    // Count from reset: rdata after 10 edges shows mtime after 9 edges
    rst      = 1'b1;
    bus.addr = BASE;
    repeat (10) @(negedge clk);
    check("mtime_cycle10", bus.rdata, 32'd9);
    check("irq_cycle10", 32'(irq), 32'h0);

    // Register table
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].we != 4'h0) bwrite(vecs[i].a, vecs[i].wd, vecs[i].we);
      bread(vecs[i].a, rd);
      $display("vec %0d %s addr=%h we=%b wd=%h rd=%h", i, vecs[i].name, vecs[i].a, vecs[i].we, vecs[i].wd, rd);
      check(vecs[i].name, rd, vecs[i].exp);
    end

    // irq[0] rises one cycle after mtime reaches 100
    bwrite(BASE + 32'h14, 32'd0, 4'hf);
    bwrite(BASE + 32'h10, 32'd100, 4'hf);
    bwrite(BASE + 32'h04, 32'd0, 4'hf);
    bwrite(BASE + 32'h00, 32'd0, 4'hf);
    repeat (100) @(negedge clk);
    check("irq0_at_mtime100", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq0_after_mtime100", 32'(irq), 32'h1);

    // Raising mtimecmp above mtime drops irq one cycle later
    bwrite(BASE + 32'h10, 32'd1000, 4'hf);
    check("irq0_cmp_raise_lag", 32'(irq), 32'h1);
    @(negedge clk);
    check("irq0_cmp_raise_drop", 32'(irq), 32'h0);

    // 64-bit wrap; irq[2] with mtimecmp=5 drops after the wrap
    bwrite(BASE + 32'h24, 32'd0, 4'hf);
    bwrite(BASE + 32'h20, 32'd5, 4'hf);
    bwrite(BASE + 32'h04, 32'hffff_ffff, 4'hf);
    bwrite(BASE + 32'h00, 32'hffff_fffe, 4'hf);
    bus.addr = BASE;
    @(negedge clk);
    check("wrap_lo_fffe", bus.rdata, 32'hffff_fffe);
    check("wrap_irq2_a", 32'(irq[2]), 32'h1);
    @(negedge clk);
    check("wrap_lo_ffff", bus.rdata, 32'hffff_ffff);
    check("wrap_irq2_b", 32'(irq[2]), 32'h1);
    @(negedge clk);
    check("wrap_lo_zero", bus.rdata, 32'h0);
    check("wrap_irq_drop", 32'(irq), 32'h0);
    bus.addr = BASE + 32'h04;
    @(negedge clk);
    check("wrap_hi_zero", bus.rdata, 32'h0);

    // div=3: one increment every 4 cycles
    bwrite(BASE + 32'h08, 32'h0000_0301, 4'hf);
    bwrite(BASE + 32'h00, 32'd0, 4'hf);
    bus.addr = BASE;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("div3_count", bus.rdata, 32'(k / 4));
    end

    // enable=0 freezes mtime and the prescaler
    bwrite(BASE + 32'h00, 32'h0000_1234, 4'hf);
    bwrite(BASE + 32'h08, 32'h0000_0300, 4'hf);
    bus.addr = BASE;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("disabled_hold", bus.rdata, 32'h0000_1234);
    end
    bwrite(BASE + 32'h08, 32'h0000_0301, 4'hf);
    bus.addr = BASE;
    repeat (3) @(negedge clk);
    check("reenable_pre_held", bus.rdata, 32'h0000_1234);
    @(negedge clk);
    check("reenable_step", bus.rdata, 32'h0000_1235);
    bwrite(BASE + 32'h08, 32'h0000_0001, 4'hf);

    // Harts 1 and 3 match together
    bwrite(BASE + 32'h14, 32'hffff_ffff, 4'hf);
    bwrite(BASE + 32'h24, 32'hffff_ffff, 4'hf);
    bwrite(BASE + 32'h1c, 32'd0, 4'hf);
    bwrite(BASE + 32'h18, 32'd50, 4'hf);
    bwrite(BASE + 32'h2c, 32'd0, 4'hf);
    bwrite(BASE + 32'h28, 32'd50, 4'hf);
    bwrite(BASE + 32'h04, 32'd0, 4'hf);
    bwrite(BASE + 32'h00, 32'd0, 4'hf);
    repeat (50) @(negedge clk);
    check("multi_irq_before", 32'(irq), 32'h0);
    @(negedge clk);
    check("multi_irq_1010", 32'(irq), 32'b1010);

    // Byte-0-only write to mtimecmp[1] lo
    bwrite(BASE + 32'h18, 32'hddcc_bb07, 4'b0001);
    bread(BASE + 32'h18, rd);
    check("cmp1_b0_only", rd, 32'h0000_0007);
    bread(BASE + 32'h1c, rd);
    check("cmp1_hi_kept", rd, 32'h0);
    check("multi_irq_kept", 32'(irq), 32'b1010);

`ifdef BOA_MTIME_SWI_EN
    bwrite(BASE + 32'h84, 32'h1, 4'hf);
    check("swi1_set", 32'(swi), 32'b0010);
    bread(BASE + 32'h84, rd);
    check("msip1_read", rd, 32'h1);
`endif

    // Reset mid-count, again with a competing write
    rst       = 1'b0;
    bus.addr  = BASE;
    bus.wdata = 32'h0000_0055;
    bus.we    = 4'hf;
    @(negedge clk);
    bus.we = 4'h0;
    check("midrst_irq", 32'(irq), 32'h0);
    check("midrst_rdata", bus.rdata, 32'h0);
`ifdef BOA_MTIME_SWI_EN
    check("midrst_swi", 32'(swi), 32'h0);
`endif
    rst      = 1'b1;
    bus.addr = BASE;
    @(negedge clk);
    check("midrst_mtime", bus.rdata, 32'h0);
    bread(BASE + 32'h08, rd);
    check("midrst_ctrl", rd, 32'h0000_0001);
    bread(BASE + 32'h18, rd);
    check("midrst_cmp1_lo", rd, 32'hffff_ffff);
    bread(BASE + 32'h2c, rd);
    check("midrst_cmp3_hi", rd, 32'hffff_ffff);
    bread(BASE + 32'h84, rd);
    check("midrst_msip1", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
